// File: rtl/lis_arb_pkg.sv
// ----------------------------------------------------------------------------
// lis_arb_pkg
// Shared types and sizing for the linear-insertion-sorter stream arbiter.
//   arb_state_t : arbiter FSM states (IDLE, FILL, DRAIN)
//   src_idx_t   : index of a requesting source (0 = pin stream, 1 = on-chip)
//   max_beats() : longest input frame accepted for a given sorter size
//   cnt_width() : beat counter width able to hold max_beats() without wrap
// ----------------------------------------------------------------------------
package lis_arb_pkg;

  localparam int LIS_SIZE_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  typedef logic src_idx_t;

  function automatic int max_beats(input int lis_size);
    return 4 * lis_size;
  endfunction

  // One spare bit so a counter can sit at exactly max_beats.
  function automatic int cnt_width(input int lis_size);
    return $clog2(4 * lis_size) + 1;
  endfunction

  localparam int MAX_BEATS = max_beats(LIS_SIZE_DEF);
  localparam int CNT_W     = cnt_width(LIS_SIZE_DEF);

endpackage

// File: rtl/lis_rr_grant.sv
// ----------------------------------------------------------------------------
// lis_rr_grant
// Two-requester round-robin picker. A lone requester always wins; when both
// request, the source named by rr_next wins. Purely combinational; the
// caller owns the rr_next state.
// Ports:
//   req[1:0]  in   request per source
//   rr_next   in   source preferred on a tie
//   gnt       out  winning source index (meaningful only when gnt_valid=1)
//   gnt_valid out  at least one source is requesting
// ----------------------------------------------------------------------------
module lis_rr_grant
  import lis_arb_pkg::*;
(
  input  logic [1:0] req,
  input  src_idx_t   rr_next,
  output src_idx_t   gnt,
  output logic       gnt_valid
);

  always_comb begin
    gnt_valid = |req;
    if (req == 2'b11) begin
      gnt = rr_next;
    end else begin
      // 2'b01 -> 0, 2'b10 -> 1, 2'b00 -> don't care (reported as 0)
      gnt = src_idx_t'(req[1]);
    end
  end

endmodule

// File: rtl/lis_stream_arbiter.sv
// ----------------------------------------------------------------------------
// lis_stream_arbiter
// Shares one linear insertion sorter between two byte-stream sources with
// frame-granular round-robin arbitration. The granted source owns the sorter
// input until its frame ends and the sorter output until that frame's result
// has been drained. No data is buffered: ready/valid/data are routed
// combinationally, only control state is registered.
//
// Ports:
//   clock, reset                 system clock, async active-high reset
//   s0_in_*  / s0_out_*          source 0 (pin stream) input / result stream
//   s1_in_*  / s1_out_*          source 1 (on-chip stream) input / result stream
//   lis_in_*                     towards the sorter core
//   lis_out_*                    from the sorter core
//   owner                        granted source, valid while busy=1
//   busy                         high in FILL or DRAIN
//   frame_done                   one-cycle pulse after a frame fully drains
//   err_spurious                 sticky, sorter produced output while IDLE
//
// state | meaning
// ------+--------------------------------------------------------------------
// IDLE  | no owner; all ready/valid outputs low; picks next source
// FILL  | owner streams bytes into the sorter; early results may flow out
// DRAIN | input closed; owner drains results until out_cnt reaches in_cnt
// ----------------------------------------------------------------------------
module lis_stream_arbiter
  import lis_arb_pkg::*;
#(
  parameter int LIS_SIZE = LIS_SIZE_DEF
) (
  input  logic       clock,
  input  logic       reset,

  input  logic       s0_in_valid,
  output logic       s0_in_ready,
  input  logic [7:0] s0_in_data,
  input  logic       s0_in_last,
  output logic       s0_out_valid,
  input  logic       s0_out_ready,
  output logic [7:0] s0_out_data,

  input  logic       s1_in_valid,
  output logic       s1_in_ready,
  input  logic [7:0] s1_in_data,
  input  logic       s1_in_last,
  output logic       s1_out_valid,
  input  logic       s1_out_ready,
  output logic [7:0] s1_out_data,

  output logic       lis_in_valid,
  input  logic       lis_in_ready,
  output logic [7:0] lis_in_data,
  output logic       lis_in_last,
  input  logic       lis_out_valid,
  output logic       lis_out_ready,
  input  logic [7:0] lis_out_data,

  output logic       owner,
  output logic       busy,
  output logic       frame_done,
  output logic       err_spurious
);

  localparam int FRAME_BEATS = max_beats(LIS_SIZE);
  localparam int CW          = cnt_width(LIS_SIZE);
  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_BEATS - 1);

  arb_state_t    state;
  src_idx_t      owner_q;
  src_idx_t      rr_next;
  logic [CW-1:0] in_cnt;
  logic [CW-1:0] out_cnt;
  logic          frame_done_q;
  logic          err_q;

  src_idx_t      gnt;
  logic          gnt_valid;

  logic          in_fill;
  logic          in_drain;
  logic          active;
  logic          own_in_valid;
  logic [7:0]    own_in_data;
  logic          own_in_last;
  logic          own_out_ready;
  logic          in_beat;
  logic          out_beat;
  logic          frame_end;
  logic          drained;
  logic [CW-1:0] in_cnt_nxt;
  logic [CW-1:0] out_cnt_nxt;

  lis_rr_grant u_rr_grant (
    .req       ({s1_in_valid, s0_in_valid}),
    .rr_next   (rr_next),
    .gnt       (gnt),
    .gnt_valid (gnt_valid)
  );

  // Owner-side selection of the two source streams.
  always_comb begin
    own_in_valid  = owner_q ? s1_in_valid  : s0_in_valid;
    own_in_data   = owner_q ? s1_in_data   : s0_in_data;
    own_in_last   = owner_q ? s1_in_last   : s0_in_last;
    own_out_ready = owner_q ? s1_out_ready : s0_out_ready;
  end

  // Stream routing. Everything is qualified by state so IDLE presents a
  // fully quiet interface on both sides.
  always_comb begin
    in_fill  = (state == FILL);
    in_drain = (state == DRAIN);
    active   = in_fill | in_drain;

    lis_in_valid = in_fill & own_in_valid;
    lis_in_data  = in_fill ? own_in_data : 8'h00;
    // Frames that never assert last are cut at the sorter capacity.
    lis_in_last  = in_fill & (own_in_last | (in_cnt == LAST_CNT));

    s0_in_ready  = in_fill & ~owner_q & lis_in_ready;
    s1_in_ready  = in_fill &  owner_q & lis_in_ready;

    // Once the input has ended, refuse results beyond the byte count sent.
    lis_out_ready = active & own_out_ready & ~(in_drain & (out_cnt == in_cnt));

    s0_out_valid = active & ~owner_q & lis_out_valid;
    s1_out_valid = active &  owner_q & lis_out_valid;
    s0_out_data  = (active & ~owner_q) ? lis_out_data : 8'h00;
    s1_out_data  = (active &  owner_q) ? lis_out_data : 8'h00;
  end

  // Beat accounting, including same-cycle input and output beats.
  always_comb begin
    in_beat     = lis_in_valid & lis_in_ready;
    out_beat    = lis_out_valid & lis_out_ready;
    in_cnt_nxt  = in_cnt + CW'(in_beat);
    out_cnt_nxt = out_cnt + CW'(out_beat);
    frame_end   = in_beat & lis_in_last;
    drained     = (out_cnt_nxt >= in_cnt_nxt);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      owner_q      <= 1'b0;
      rr_next      <= 1'b0;
      in_cnt       <= '0;
      out_cnt      <= '0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (lis_out_valid) begin
            err_q <= 1'b1;
          end
          // The grant cycle moves no data; routing opens next cycle.
          if (gnt_valid) begin
            owner_q <= gnt;
            in_cnt  <= '0;
            out_cnt <= '0;
            state   <= FILL;
          end
        end
        FILL: begin
          in_cnt  <= in_cnt_nxt;
          out_cnt <= out_cnt_nxt;
          if (frame_end) begin
            if (drained) begin
              // Sorter already delivered every byte of this frame.
              state        <= IDLE;
              frame_done_q <= 1'b1;
              rr_next      <= ~owner_q;
            end else begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          out_cnt <= out_cnt_nxt;
          if (drained) begin
            state        <= IDLE;
            frame_done_q <= 1'b1;
            rr_next      <= ~owner_q;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    owner        = owner_q;
    busy         = (state != IDLE);
    frame_done   = frame_done_q;
    err_spurious = err_q;
  end

endmodule

// File: tb/tb_lis_stream_arbiter.sv
// ----------------------------------------------------------------------------
// tb_lis_stream_arbiter
// Directed bench for lis_stream_arbiter. A behavioural sorter sorts whatever
// bytes actually reach lis_in and returns them ascending; per-source expected
// result queues are filled from the stimulus when a frame is loaded and
// popped as result bytes appear on s0_out / s1_out.
// ----------------------------------------------------------------------------
module tb_lis_stream_arbiter;
  import lis_arb_pkg::*;

  localparam int NB = MAX_BEATS;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       s0_in_valid, s0_in_ready, s0_in_last, s0_out_valid, s0_out_ready;
  logic [7:0] s0_in_data, s0_out_data;
  logic       s1_in_valid, s1_in_ready, s1_in_last, s1_out_valid, s1_out_ready;
  logic [7:0] s1_in_data, s1_out_data;
  logic       lis_in_valid, lis_in_ready, lis_in_last, lis_out_valid, lis_out_ready;
  logic [7:0] lis_in_data, lis_out_data;
  logic       owner, busy, frame_done, err_spurious;

  always #5 clock = ~clock;

  lis_stream_arbiter #(.LIS_SIZE(LIS_SIZE_DEF)) dut (
    .clock        (clock),
    .reset        (reset),
    .s0_in_valid  (s0_in_valid),
    .s0_in_ready  (s0_in_ready),
    .s0_in_data   (s0_in_data),
    .s0_in_last   (s0_in_last),
    .s0_out_valid (s0_out_valid),
    .s0_out_ready (s0_out_ready),
    .s0_out_data  (s0_out_data),
    .s1_in_valid  (s1_in_valid),
    .s1_in_ready  (s1_in_ready),
    .s1_in_data   (s1_in_data),
    .s1_in_last   (s1_in_last),
    .s1_out_valid (s1_out_valid),
    .s1_out_ready (s1_out_ready),
    .s1_out_data  (s1_out_data),
    .lis_in_valid (lis_in_valid),
    .lis_in_ready (lis_in_ready),
    .lis_in_data  (lis_in_data),
    .lis_in_last  (lis_in_last),
    .lis_out_valid(lis_out_valid),
    .lis_out_ready(lis_out_ready),
    .lis_out_data (lis_out_data),
    .owner        (owner),
    .busy         (busy),
    .frame_done   (frame_done),
    .err_spurious (err_spurious)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] src_d0[$], src_d1[$];
  logic       src_l0[$], src_l1[$];
  logic [7:0] exp0[$], exp1[$];
  logic [7:0] sort_in[$], sort_out[$];
  int         owner_log[$];

  int early_n = 0, early_done = 0;
  bit rand_in_ready = 0, toggle_out = 0, tog = 0, spur = 0;
  int out_beats0 = 0, out_beats1 = 0, fd_cnt = 0, s1_valid_seen = 0;
  int nonown_ready = 0, flush_at1 = -1;
  bit busy_q = 0, fr_last_seen = 0;
  int fr_in = 0, fr_last_pos = 0, fr_out_pre = 0, fr_out_post = 0, fr_late_ready = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // mode 0: random bytes; mode 1: first four bytes are 0..3 (smallest,
  // ascending) so the sorter may return them before the frame ends.
  task automatic load_frame(input int src, input int n, input int last_at, input int mode);
    logic [7:0] d;
    logic [7:0] fr[$];
    int flen;
    flen = (last_at >= 0 && last_at < n) ? last_at + 1 : n;
    if (flen > NB) flen = NB;
    for (int i = 0; i < n; i++) begin
      if (mode == 1) d = (i < 4) ? 8'(i) : 8'($urandom_range(4, 255));
      else           d = 8'($urandom_range(0, 255));
      if (src == 0) begin src_d0.push_back(d); src_l0.push_back(i == last_at); end
      else          begin src_d1.push_back(d); src_l1.push_back(i == last_at); end
      if (i < flen) fr.push_back(d);
    end
    fr.sort();
    foreach (fr[i]) begin
      if (src == 0) exp0.push_back(fr[i]);
      else          exp1.push_back(fr[i]);
    end
  endtask

  // One clock cycle: drive at the falling edge, observe 1 ns later, then
  // wait for the next falling edge.
  task automatic cycle();
    logic [7:0] srt[$];
    bit shown;
    s0_in_valid   = src_d0.size() > 0;
    s0_in_data    = s0_in_valid ? src_d0[0] : 8'h00;
    s0_in_last    = s0_in_valid ? src_l0[0] : 1'b0;
    s1_in_valid   = src_d1.size() > 0;
    s1_in_data    = s1_in_valid ? src_d1[0] : 8'h00;
    s1_in_last    = s1_in_valid ? src_l1[0] : 1'b0;
    lis_in_ready  = rand_in_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    shown         = sort_out.size() > 0;
    lis_out_valid = spur || shown;
    lis_out_data  = shown ? sort_out[0] : 8'h00;
    s0_out_ready  = toggle_out ? tog : 1'b1;
    s1_out_ready  = 1'b1;
    tog = ~tog;
    #1;
    if (busy && !busy_q) begin
      owner_log.push_back(int'(owner));
      fr_in = 0; fr_last_seen = 0; fr_last_pos = 0;
      fr_out_pre = 0; fr_out_post = 0; fr_late_ready = 0;
    end
    if (spur && !busy) check("idle_out_ready", lis_out_ready, 0);
    if (s1_out_valid) s1_valid_seen++;
    if (busy && ((owner == 1'b0 && s1_in_ready) || (owner == 1'b1 && s0_in_ready))) nonown_ready++;
    if (busy && fr_last_seen && (s0_in_ready || s1_in_ready)) fr_late_ready++;
    if (s0_in_valid && s0_in_ready) begin void'(src_d0.pop_front()); void'(src_l0.pop_front()); end
    if (s1_in_valid && s1_in_ready) begin void'(src_d1.pop_front()); void'(src_l1.pop_front()); end
    if (lis_out_valid && lis_out_ready) begin
      if (shown) void'(sort_out.pop_front());
      if (fr_last_seen) fr_out_post++;
      else              fr_out_pre++;
    end
    if (lis_in_valid && lis_in_ready) begin
      fr_in++;
      sort_in.push_back(lis_in_data);
      if (lis_in_last) begin
        srt = sort_in;
        srt.sort();
        for (int i = early_done; i < srt.size(); i++) sort_out.push_back(srt[i]);
        sort_in.delete();
        early_done   = 0;
        fr_last_seen = 1;
        fr_last_pos  = fr_in;
      end
    end
    if (early_n > 0 && early_done < early_n && sort_in.size() > early_done && sort_out.size() == 0) begin
      sort_out.push_back(sort_in[early_done]);
      early_done++;
    end
    if (s0_out_valid && s0_out_ready) begin
      out_beats0++;
      check("s0_out_expected", exp0.size() > 0, 1);
      if (exp0.size() > 0) check("s0_out_data", s0_out_data, exp0.pop_front());
    end
    if (s1_out_valid && s1_out_ready) begin
      out_beats1++;
      check("s1_out_expected", exp1.size() > 0, 1);
      if (exp1.size() > 0) check("s1_out_data", s1_out_data, exp1.pop_front());
    end
    if (frame_done) begin
      fd_cnt++;
      check("busy_at_done", busy, 0);
    end
    if (out_beats1 == flush_at1) begin
      src_d1.delete(); src_l1.delete(); flush_at1 = -1;
    end
    busy_q = busy;
    @(negedge clock);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_done(input string tag, input int budget);
    int start;
    int k;
    start = fd_cnt;
    k = 0;
    while (fd_cnt == start && k < budget) begin
      cycle();
      k++;
    end
    check(tag, fd_cnt > start, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int ol0, ob0, ob1, fd0, sv0, k;
    s0_in_valid = 0; s0_in_data = 0; s0_in_last = 0; s0_out_ready = 0;
    s1_in_valid = 0; s1_in_data = 0; s1_in_last = 0; s1_out_ready = 0;
    lis_in_ready = 0; lis_out_valid = 0; lis_out_data = 0;
    reset = 1'b1;
    #2;
    check("rst_owner", owner, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_err", err_spurious, 0);
    check("rst_quiet", {s0_in_ready, s1_in_ready, lis_in_valid, lis_out_ready, s0_out_valid, s1_out_valid}, 0);
    @(negedge clock);
    reset = 1'b0;
    run(2);

    // Contention from reset: tie -> s0, pending tie -> s1, lone s1, tie -> s0.
    ol0 = owner_log.size();
    load_frame(0, 8, 7, 0);
    load_frame(1, 8, 7, 0);
    wait_done("c_done_a", 200);
    wait_done("c_done_b", 200);
    load_frame(1, 6, 5, 0);
    wait_done("c_done_c", 200);
    load_frame(0, 5, 4, 0);
    load_frame(1, 5, 4, 0);
    wait_done("c_done_d", 200);
    wait_done("c_done_e", 200);
    check("c_frames", owner_log.size() - ol0, 5);
    if (owner_log.size() - ol0 == 5) begin
      check("c_owner0", owner_log[ol0 + 0], 0);
      check("c_owner1", owner_log[ol0 + 1], 1);
      check("c_owner2", owner_log[ol0 + 2], 1);
      check("c_owner3", owner_log[ol0 + 3], 0);
      check("c_owner4", owner_log[ol0 + 4], 1);
    end
    check("c_exp_empty", exp0.size() + exp1.size(), 0);
    check("c_nonowner_ready", nonown_ready, 0);
    run(2);

    // Single 32-byte frame from s0.
    fd0 = fd_cnt; sv0 = s1_valid_seen; ob0 = out_beats0;
    load_frame(0, 32, 31, 0);
    wait_done("t1_done", 300);
    check("t1_owner", owner_log[owner_log.size() - 1], 0);
    check("t1_last_pos", fr_last_pos, 32);
    check("t1_out_beats", out_beats0 - ob0, 32);
    check("t1_exp_empty", exp0.size(), 0);
    run(4);
    check("t1_done_once", fd_cnt - fd0, 1);
    check("t1_s1_quiet", s1_valid_seen - sv0, 0);

    // s1 sends 40 bytes without last: cut at beat 32, remainder held off.
    ob1 = out_beats1;
    flush_at1 = out_beats1 + 32;
    load_frame(1, 40, -1, 0);
    wait_done("t3_done", 300);
    check("t3_owner", owner_log[owner_log.size() - 1], 1);
    check("t3_forced_last", fr_last_pos, 32);
    check("t3_in_beats", fr_in, 32);
    check("t3_ready_after_last", fr_late_ready, 0);
    check("t3_out_beats", out_beats1 - ob1, 32);
    check("t3_exp_empty", exp1.size(), 0);
    run(3);
    check("t3_idle_after", busy, 0);

    // Backpressure on both sides.
    rand_in_ready = 1; toggle_out = 1;
    ob0 = out_beats0;
    load_frame(0, 32, 31, 0);
    wait_done("t4_done", 600);
    check("t4_out_beats", out_beats0 - ob0, 32);
    check("t4_exp_empty", exp0.size(), 0);
    rand_in_ready = 0; toggle_out = 0;
    run(2);

    // Sorter returns four results while the frame is still filling.
    early_n = 4;
    load_frame(0, 32, 31, 1);
    wait_done("t5_done", 300);
    check("t5_early_beats", fr_out_pre, 4);
    check("t5_drain_beats", fr_out_post, 28);
    check("t5_exp_empty", exp0.size(), 0);
    early_n = 0;
    run(2);

    // Spurious sorter output while idle.
    check("t6_err_before", err_spurious, 0);
    spur = 1;
    run(2);
    spur = 0;
    run(1);
    check("t6_err_set", err_spurious, 1);
    run(3);
    check("t6_err_sticky", err_spurious, 1);
    check("t6_still_idle", busy, 0);

    // Reset after the 10th input beat of a frame.
    load_frame(0, 32, 31, 0);
    fr_in = 0;
    k = 0;
    while (fr_in < 10 && k < 100) begin
      cycle();
      k++;
    end
    check("t7_reach_beat10", fr_in, 10);
    check("t7_busy_pre", busy, 1);
    reset = 1'b1;
    #1;
    check("t7_busy", busy, 0);
    check("t7_owner", owner, 0);
    check("t7_err_cleared", err_spurious, 0);
    check("t7_frame_done", frame_done, 0);
    check("t7_quiet", {s0_in_ready, s1_in_ready, lis_in_valid, lis_in_last, lis_out_ready, s0_out_valid, s1_out_valid}, 0);
    src_d0.delete(); src_l0.delete(); exp0.delete();
    sort_in.delete(); sort_out.delete(); early_done = 0; busy_q = 0;
    @(negedge clock);
    reset = 1'b0;
    ob1 = out_beats1;
    load_frame(1, 16, 15, 0);
    wait_done("t7_new_done", 300);
    check("t7_new_owner", owner_log[owner_log.size() - 1], 1);
    check("t7_new_last_pos", fr_last_pos, 16);
    check("t7_new_out_beats", out_beats1 - ob1, 16);
    check("t7_new_exp_empty", exp1.size(), 0);
    check("t7_err_still_clear", err_spurious, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
